// File: rtl/compressor_ctrl_fsm_if.sv
// Bundle of the controller's sensor, command and PWM-stage signals.
interface compressor_ctrl_fsm_if;
    logic               clk_1khz;
    logic               temp_valid;
    logic [11:0]        temp_current;
    logic [11:0]        temp_setpoint;
    logic [7:0]         hysteresis;
    logic               defrost_req;
    logic               fault;
    logic               fault_clr;
    logic               pwm_enable;
    logic [9:0]         duty_cycle;
    logic               soft_start;
    logic [1:0]         state;

    // Drives sensor/command inputs, observes PWM-stage outputs.
    modport master (
        output clk_1khz, temp_valid, temp_current, temp_setpoint, hysteresis,
        output defrost_req, fault, fault_clr,
        input  pwm_enable, duty_cycle, soft_start, state
    );

    // Controller side.
    modport slave (
        input  clk_1khz, temp_valid, temp_current, temp_setpoint, hysteresis,
        input  defrost_req, fault, fault_clr,
        output pwm_enable, duty_cycle, soft_start, state
    );
endinterface

// File: rtl/compressor_ctrl_fsm.sv
// Compressor protection controller: hysteresis thermostat with anti-short-cycle
// timing, defrost lockout and latched fault shutdown, feeding the PWM stage.
module compressor_ctrl_fsm #(
    parameter logic [20:0] MIN_ON_MS  = 21'd60000,
    parameter logic [20:0] MIN_OFF_MS = 21'd180000,
    parameter logic [20:0] DEFROST_MS = 21'd1200000,
    parameter logic [9:0]  DUTY_MIN   = 10'd256,
    parameter logic [3:0]  KP         = 4'd8
) (
    input logic                  clk,
    input logic                  rst_n,
    compressor_ctrl_fsm_if.slave bus
);
    localparam logic [1:0]  StOff     = 2'd0;
    localparam logic [1:0]  StRun     = 2'd1;
    localparam logic [1:0]  StDefrost = 2'd2;
    localparam logic [1:0]  StFault   = 2'd3;
    localparam logic [20:0] TimerMax  = 21'h1FFFFF;

    logic [1:0]         state_q, state_d;
    logic [20:0]        timer_q, timer_d;
    logic [11:0]        temp_q, temp_d;
    logic               temp_seen_q, temp_seen_d;
    logic               pwm_enable_q, pwm_enable_d;
    logic [9:0]         duty_q, duty_d;
    logic               soft_start_q, soft_start_d;

    logic signed [13:0] sp_ext, temp_ext, hyst_ext, hi, lo;
    logic signed [12:0] err;
    logic [17:0]        duty_raw;
    logic [9:0]         duty_run;
    logic               on_elapsed, off_elapsed, defrost_elapsed;

    // Thresholds and proportional duty from the latched sample.
    always_comb begin
        sp_ext   = {{2{bus.temp_setpoint[11]}}, bus.temp_setpoint};
        temp_ext = {{2{temp_q[11]}}, temp_q};
        hyst_ext = {6'd0, bus.hysteresis};
        hi       = sp_ext + hyst_ext;
        lo       = sp_ext - hyst_ext;
        err      = {temp_q[11], temp_q} - {bus.temp_setpoint[11], bus.temp_setpoint};
        // err > 0 here means err[11:0] is its magnitude (at most 4095).
        duty_raw = {8'd0, DUTY_MIN} + ({6'd0, err[11:0]} * {14'd0, KP});
        if (err[12] || (err == 13'sd0)) begin
            duty_run = DUTY_MIN;
        end else if (duty_raw > 18'd1023) begin
            duty_run = 10'd1023;
        end else begin
            duty_run = duty_raw[9:0];
        end
        on_elapsed      = (timer_q >= MIN_ON_MS);
        off_elapsed     = (timer_q >= MIN_OFF_MS);
        defrost_elapsed = (timer_q >= DEFROST_MS);
    end

    // Next state: fault beats defrost beats temperature.
    always_comb begin
        state_d = state_q;
        if ((state_q != StFault) && bus.fault) begin
            state_d = StFault;
        end else begin
            case (state_q)
                StOff: begin
                    if (temp_seen_q && (temp_ext > hi) && off_elapsed && !bus.defrost_req) begin
                        state_d = StRun;
                    end
                end
                StRun: begin
                    if (bus.defrost_req && on_elapsed) begin
                        state_d = StDefrost;
                    end else if ((temp_ext <= lo) && on_elapsed) begin
                        state_d = StOff;
                    end
                end
                StDefrost: begin
                    if (defrost_elapsed) begin
                        state_d = StOff;
                    end
                end
                default: begin
                    if (bus.fault_clr && !bus.fault) begin
                        state_d = StOff;
                    end
                end
            endcase
        end
    end

    // Timer restarts on every state entry, otherwise counts ticks and saturates.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (bus.clk_1khz && (timer_q != TimerMax)) begin
            timer_d = timer_q + 21'd1;
        end
    end

    // Sample latch and outputs derived from the state being entered.
    always_comb begin
        temp_d       = temp_q;
        temp_seen_d  = temp_seen_q;
        if (bus.temp_valid) begin
            temp_d      = bus.temp_current;
            temp_seen_d = 1'b1;
        end
        pwm_enable_d = (state_d == StRun);
        duty_d       = (state_d == StRun) ? duty_run : 10'd0;
        soft_start_d = (state_d != StFault);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StOff;
            timer_q      <= '0;
            temp_q       <= '0;
            temp_seen_q  <= 1'b0;
            pwm_enable_q <= 1'b0;
            duty_q       <= '0;
            soft_start_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            temp_q       <= temp_d;
            temp_seen_q  <= temp_seen_d;
            pwm_enable_q <= pwm_enable_d;
            duty_q       <= duty_d;
            soft_start_q <= soft_start_d;
        end
    end

    assign bus.pwm_enable = pwm_enable_q;
    assign bus.duty_cycle = duty_q;
    assign bus.soft_start = soft_start_q;
    assign bus.state      = state_q;
endmodule
